// File: rtl/if_fetch_buf_if.sv
// Fetch-buffer bus bundle: IRAM read port plus the valid/ready link to ID.
// master = fetch buffer side, slave = IRAM/ID side.
interface if_fetch_buf_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            iram_req;
    logic [XLEN-1:0] iram_addr;
    logic [ILEN-1:0] iram_rdata;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [ILEN-1:0] id_inst;

    modport master (
        output iram_req, iram_addr, id_valid, id_pc, id_inst,
        input  iram_rdata, id_ready
    );

    modport slave (
        input  iram_req, iram_addr, id_valid, id_pc, id_inst,
        output iram_rdata, id_ready
    );
endinterface

// File: rtl/if_fetch_buf.sv
// Fetch stage: issues IRAM reads at the PC, pairs late read data with its PC in a
// small FIFO feeding ID, back-pressures the PC register and flushes on branch/jump.
module if_fetch_buf #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            iram_en_i,
    input  logic            bj_flag,
    output logic            pipe_stall,
    if_fetch_buf_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

    logic [DEPTH-1:0][XLEN-1:0] fifo_pc;
    logic [DEPTH-1:0][ILEN-1:0] fifo_inst;
    logic [AW-1:0]              rd_ptr;
    logic [AW-1:0]              wr_ptr;
    logic [CW-1:0]              count;
    logic                       req_vld_q;
    logic [XLEN-1:0]            req_pc_q;
    logic                       pop;
    logic                       push;
    logic [CW:0]                occ_next;

    assign pop  = bus.id_valid & bus.id_ready;
    assign push = req_vld_q & ~bj_flag;

    // Occupancy after this edge without a new request; an in-flight read already owns a slot.
    assign occ_next   = {1'b0, count} + (CW+1)'(req_vld_q) - (CW+1)'(pop);
    assign pipe_stall = (occ_next >= FULL);

    assign bus.iram_req  = iram_en_i & ~bj_flag & ~pipe_stall & ~rst;
    assign bus.iram_addr = pc_i;

    assign bus.id_valid = (count != '0);
    assign bus.id_pc    = fifo_pc[rd_ptr];
    assign bus.id_inst  = fifo_inst[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            req_vld_q <= 1'b0;
            req_pc_q  <= '0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            fifo_pc   <= '0;
            fifo_inst <= '0;
        end else begin
            req_vld_q <= bus.iram_req;
            if (bus.iram_req)
                req_pc_q <= pc_i;

            // A flush drops both buffered entries and the response arriving this cycle.
            if (bj_flag) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]   <= req_pc_q;
                    fifo_inst[wr_ptr] <= bus.iram_rdata;
                    wr_ptr            <= wr_ptr + AW'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule
